// File: rtl/capture_sequencer_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic capture sequencer.
// Used by capture_sequencer and rr_arbiter. Optional feature macro: CAPTURE_TAG_EN.
package capture_pkg;

   // Width of the per-frame sample index carried on out_tag.
   localparam int TAG_W = 16;

   // Frame sequencing states: idle, transmit burst, receive window.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BURST  = 2'd1,
      LISTEN = 2'd2
   } state_t;

   // Channel index width; a single channel still needs one bit.
   function automatic int chw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/capture_sequencer_arbiter.sv
// Round-robin arbiter for the capture holding registers. The grant is the
// lowest requesting channel above the last granted one, wrapping around.
module rr_arbiter
   import capture_pkg::*;
#(
   parameter int NUM_CH = 5,
   parameter int CHW    = chw(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [CHW-1:0]    grant
);

   localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

   logic [CHW-1:0] ptr_q;
   logic [CHW-1:0] ptr_d;
   logic           found;
   int             idx;

   // Scan upward from the channel after the pointer and take the first request.
   always_comb begin
      grant = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(ptr_q) + i) % NUM_CH;
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = CHW'(idx);
         end
      end
   end

   // The pointer remembers the last channel whose word was accepted.
   always_comb begin
      ptr_d = ptr_q;
      if (clear) begin
         ptr_d = LAST_CH;
      end else if (advance) begin
         ptr_d = grant;
      end
   end

   // Pointer register; starts on the last channel so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= LAST_CH;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/capture_sequencer.sv
// Multi-channel ultrasonic capture sequencer: runs the transmit/listen frame,
// launches the enabled ADC SPI masters on a common sample tick, captures each
// result on its FIN and merges them round-robin into one valid/ready stream.
// Optional feature macro: CAPTURE_TAG_EN (out_tag carries the sample index).
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int  NUM_CH     = 5,
   parameter int  DW         = 16,
   parameter int  TONE_DIV   = 1024,
   parameter int  BURST_LEN  = 32,
   parameter int  FRAME_LEN  = 588800,
   parameter int  SAMPLE_DIV = 64,
   localparam int CHW        = chw(NUM_CH)
) (
   input  logic                 SYS_CLK,
   input  logic                 reset,
   input  logic                 on,
   input  logic [NUM_CH-1:0]    ch_mask,
   input  logic [NUM_CH-1:0]    adc_fin,
   input  logic [NUM_CH*DW-1:0] adc_data,
   output logic [NUM_CH-1:0]    adc_ena,
   output logic                 tx_out,
   output logic                 frame_start,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [CHW-1:0]       out_ch,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 overrun
);

   localparam int FW = $clog2(FRAME_LEN);
   localparam int TW = $clog2(TONE_DIV);
   localparam int SW = $clog2(SAMPLE_DIV);

   localparam logic [FW-1:0]     FRAME_LAST  = FW'(FRAME_LEN - 1);
   localparam logic [FW-1:0]     BURST_LAST  = FW'(BURST_LEN - 1);
   localparam logic [SW-1:0]     SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [NUM_CH-1:0] ONE_HOT0    = NUM_CH'(1);

   state_t            state_q, state_d;
   logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
   logic [TW-1:0]     tone_cnt_q, tone_cnt_d;
   logic [SW-1:0]     sample_cnt_q, sample_cnt_d;
   logic [NUM_CH-1:0] active_mask_q, active_mask_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] hold_v_q, hold_v_d;
   logic [DW-1:0]     hold_q [NUM_CH];
   logic [DW-1:0]     hold_d [NUM_CH];
   logic              overrun_q, overrun_d;
   logic              stall_q, stall_d;
   logic [CHW-1:0]    stall_ch_q, stall_ch_d;
`ifdef CAPTURE_TAG_EN
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [TAG_W-1:0]  hold_tag_q [NUM_CH];
   logic [TAG_W-1:0]  hold_tag_d [NUM_CH];
`endif

   logic              running;
   logic              tick;
   logic              frame_wrap;
   logic              accept;
   logic [CHW-1:0]    grant;
   logic [NUM_CH-1:0] capture;
   logic [NUM_CH-1:0] capture_ok;
   logic [NUM_CH-1:0] release_ch;
   logic [NUM_CH-1:0] arb_req;

   assign running    = (state_q != IDLE);
   assign tick       = running && (sample_cnt_q == SAMPLE_LAST);
   assign frame_wrap = (state_q == LISTEN) && (frame_cnt_q == FRAME_LAST);
   assign out_valid  = |hold_v_q;
   assign accept     = out_valid & out_ready;
   assign release_ch = accept ? (ONE_HOT0 << grant) : '0;
   assign capture    = adc_fin & pending_q;
   assign capture_ok = capture & (~hold_v_q | release_ch);
   assign arb_req    = stall_q ? (ONE_HOT0 << stall_ch_q) : hold_v_q;

   assign adc_ena     = pending_q;
   assign tx_out      = tone_cnt_q[TW-1] & (state_q == BURST);
   assign frame_start = running && (frame_cnt_q == '0);
   assign out_data    = hold_q[grant];
   assign out_ch      = grant;
   assign overrun     = overrun_q;
`ifdef CAPTURE_TAG_EN
   assign out_tag     = hold_tag_q[grant];
`else
   assign out_tag     = '0;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CHW    (CHW)
   ) u_arbiter (
      .clk     (SYS_CLK),
      .reset   (reset),
      .clear   (~on),
      .req     (arb_req),
      .advance (accept),
      .grant   (grant)
   );

   // Frame sequencing: burst/listen state, frame and sample counters, tone.
   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      sample_cnt_d  = sample_cnt_q;
      active_mask_d = active_mask_q;
      tone_cnt_d    = tone_cnt_q + TW'(1);
      if (!on) begin
         state_d       = IDLE;
         frame_cnt_d   = '0;
         sample_cnt_d  = '0;
         active_mask_d = '0;
      end else begin
         if (running) begin
            sample_cnt_d = (frame_wrap || tick) ? '0 : sample_cnt_q + SW'(1);
         end
         case (state_q)
            IDLE: begin
               state_d       = BURST;
               active_mask_d = ch_mask;
            end
            BURST: begin
               frame_cnt_d = frame_cnt_q + FW'(1);
               if (frame_cnt_q == BURST_LAST) begin
                  state_d = LISTEN;
               end
            end
            LISTEN: begin
               if (frame_wrap) begin
                  state_d       = BURST;
                  frame_cnt_d   = '0;
                  active_mask_d = ch_mask;
               end else begin
                  frame_cnt_d = frame_cnt_q + FW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Conversion launch, result capture, loss detection and output stall lock.
   always_comb begin
      pending_d  = pending_q & ~adc_fin;
      hold_v_d   = (hold_v_q & ~release_ch) | capture_ok;
      overrun_d  = overrun_q;
      stall_d    = out_valid & ~out_ready;
      stall_ch_d = grant;
      for (int k = 0; k < NUM_CH; k++) begin
         hold_d[k] = capture_ok[k] ? adc_data[k*DW +: DW] : hold_q[k];
      end
`ifdef CAPTURE_TAG_EN
      tag_d = tag_q;
      if (frame_wrap) begin
         tag_d = '0;
      end else if (tick && (pending_q == '0)) begin
         tag_d = tag_q + TAG_W'(1);
      end
      for (int k = 0; k < NUM_CH; k++) begin
         hold_tag_d[k] = capture_ok[k] ? tag_q : hold_tag_q[k];
      end
`endif
      if (tick) begin
         if (pending_q == '0) begin
            pending_d = active_mask_q;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if ((capture & ~capture_ok) != '0) begin
         overrun_d = 1'b1;
      end
      if (!on) begin
         pending_d  = '0;
         hold_v_d   = '0;
         overrun_d  = 1'b0;
         stall_d    = 1'b0;
         stall_ch_d = '0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_d[k] = '0;
         end
`ifdef CAPTURE_TAG_EN
         tag_d = '0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_tag_d[k] = '0;
         end
`endif
      end
   end

   // State register for the whole sequencer with synchronous reset.
   always_ff @(posedge SYS_CLK) begin
      if (reset) begin
         state_q       <= IDLE;
         frame_cnt_q   <= '0;
         tone_cnt_q    <= '0;
         sample_cnt_q  <= '0;
         active_mask_q <= '0;
         pending_q     <= '0;
         hold_v_q      <= '0;
         overrun_q     <= 1'b0;
         stall_q       <= 1'b0;
         stall_ch_q    <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_q[k] <= '0;
         end
`ifdef CAPTURE_TAG_EN
         tag_q <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_tag_q[k] <= '0;
         end
`endif
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         tone_cnt_q    <= tone_cnt_d;
         sample_cnt_q  <= sample_cnt_d;
         active_mask_q <= active_mask_d;
         pending_q     <= pending_d;
         hold_v_q      <= hold_v_d;
         overrun_q     <= overrun_d;
         stall_q       <= stall_d;
         stall_ch_q    <= stall_ch_d;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_q[k] <= hold_d[k];
         end
`ifdef CAPTURE_TAG_EN
         tag_q <= tag_d;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_tag_q[k] <= hold_tag_d[k];
         end
`endif
      end
   end

endmodule
